// File: rtl/traffic_pkg.sv
// Shared definitions for intersection phase controllers: phase codes and lamp encodings.
package traffic_pkg;

  localparam logic [2:0] ST_AR_A  = 3'd0;
  localparam logic [2:0] ST_NS_G  = 3'd1;
  localparam logic [2:0] ST_NS_Y  = 3'd2;
  localparam logic [2:0] ST_AR_B  = 3'd3;
  localparam logic [2:0] ST_EW_G  = 3'd4;
  localparam logic [2:0] ST_EW_Y  = 3'd5;
  localparam logic [2:0] ST_EMERG = 3'd6;

  // Lamp code is {red, yellow, green}
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

endpackage

// File: rtl/phase_timer.sv
// Per-phase tick down-counter: loaded with DUR-1 on each phase change, counts tick_en strobes.
module phase_timer #(
  parameter logic [7:0] RST_VAL = 8'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] load_val,
  input  logic       load,
  input  logic       tick_en,
  output logic       expired
);

  logic [7:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (tick_en && (cnt != 8'd0)) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign expired = (cnt == 8'd0);

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Two-axis intersection sequencer with all-red clearance, pedestrian latches and emergency preemption.
module traffic_phase_sequencer #(
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 3,
  parameter int ALLRED_TICKS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_en,
  input  logic       ped_req_ns,
  input  logic       ped_req_ew,
  input  logic       emerg_req,
  input  logic       emerg_dir,
  output logic [2:0] light_ns,
  output logic [2:0] light_ew,
  output logic       walk_ns,
  output logic       walk_ew,
  output logic [2:0] phase
);
  import traffic_pkg::*;

  localparam logic [7:0] LD_G = 8'(GREEN_TICKS - 1);
  localparam logic [7:0] LD_Y = 8'(YELLOW_TICKS - 1);
  localparam logic [7:0] LD_A = 8'(ALLRED_TICKS - 1);

  logic [2:0] state, state_nx;
  logic       axis, axis_nx;       // held emergency axis, 1 = EW
  logic       ped_ns_q, ped_ew_q, ped_ns_nx, ped_ew_nx;
  logic [2:0] light_ns_nx, light_ew_nx;
  logic       walk_ns_nx, walk_ew_nx;
  logic       ld, expired, step;
  logic [7:0] ld_val;

  function automatic logic [7:0] load_for(input logic [2:0] s);
    case (s)
      ST_NS_G, ST_EW_G: load_for = LD_G;
      ST_NS_Y, ST_EW_Y: load_for = LD_Y;
      ST_AR_A, ST_AR_B: load_for = LD_A;
      default:          load_for = 8'd0;
    endcase
  endfunction

  phase_timer #(.RST_VAL(LD_A)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load_val (ld_val),
    .load     (ld),
    .tick_en  (tick_en),
    .expired  (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_AR_A;
      axis     <= 1'b0;
      ped_ns_q <= 1'b0;
      ped_ew_q <= 1'b0;
      light_ns <= LAMP_RED;
      light_ew <= LAMP_RED;
      walk_ns  <= 1'b0;
      walk_ew  <= 1'b0;
    end else begin
      state    <= state_nx;
      axis     <= axis_nx;
      ped_ns_q <= ped_ns_nx;
      ped_ew_q <= ped_ew_nx;
      light_ns <= light_ns_nx;
      light_ew <= light_ew_nx;
      walk_ns  <= walk_ns_nx;
      walk_ew  <= walk_ew_nx;
    end
  end

  // Preemption is checked every clk and overrides the tick-driven timer expiry
  always_comb begin
    state_nx = state;
    axis_nx  = axis;
    step     = tick_en && expired;
    case (state)
      ST_AR_A: if (step) begin
        state_nx = emerg_req ? ST_EMERG : ST_NS_G;
        if (emerg_req) axis_nx = emerg_dir;
      end
      ST_NS_G: if (emerg_req) begin
        state_nx = emerg_dir ? ST_NS_Y : ST_EMERG;
        if (!emerg_dir) axis_nx = 1'b0;
      end else if (step) begin
        state_nx = ST_NS_Y;
      end
      ST_NS_Y: if (step) state_nx = ST_AR_B;
      ST_AR_B: if (step) begin
        state_nx = emerg_req ? ST_EMERG : ST_EW_G;
        if (emerg_req) axis_nx = emerg_dir;
      end
      ST_EW_G: if (emerg_req) begin
        state_nx = emerg_dir ? ST_EMERG : ST_EW_Y;
        if (emerg_dir) axis_nx = 1'b1;
      end else if (step) begin
        state_nx = ST_EW_Y;
      end
      ST_EW_Y: if (step) state_nx = ST_AR_A;
      ST_EMERG: if (!emerg_req) state_nx = axis ? ST_EW_Y : ST_NS_Y;
      default: begin
        state_nx = ST_AR_A;
        axis_nx  = 1'b0;
      end
    endcase
    ld     = (state_nx != state);
    ld_val = load_for(state_nx);
  end

  // A walk lamp is granted from the latch only on entry to its green; a request in that cycle re-arms the latch
  always_comb begin
    light_ns_nx = LAMP_RED;
    light_ew_nx = LAMP_RED;
    walk_ns_nx  = 1'b0;
    walk_ew_nx  = 1'b0;
    ped_ns_nx   = ped_ns_q | ped_req_ns;
    ped_ew_nx   = ped_ew_q | ped_req_ew;
    case (state_nx)
      ST_NS_G: begin
        light_ns_nx = LAMP_GRN;
        if (state == ST_NS_G) begin
          walk_ns_nx = walk_ns;
        end else begin
          walk_ns_nx = ped_ns_q;
          ped_ns_nx  = ped_req_ns;
        end
      end
      ST_NS_Y: light_ns_nx = LAMP_YEL;
      ST_EW_G: begin
        light_ew_nx = LAMP_GRN;
        if (state == ST_EW_G) begin
          walk_ew_nx = walk_ew;
        end else begin
          walk_ew_nx = ped_ew_q;
          ped_ew_nx  = ped_req_ew;
        end
      end
      ST_EW_Y: light_ew_nx = LAMP_YEL;
      ST_EMERG: begin
        if (axis_nx) light_ew_nx = LAMP_GRN;
        else         light_ns_nx = LAMP_GRN;
      end
      default: ;
    endcase
    if (state > ST_EMERG) begin
      ped_ns_nx = 1'b0;
      ped_ew_nx = 1'b0;
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Randomized bench for traffic_phase_sequencer against a tick-counting behavioural model.
module tb_traffic_phase_sequencer;

  localparam int G = 8;
  localparam int Y = 3;
  localparam int A = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_en = 1'b0, ped_req_ns = 1'b0, ped_req_ew = 1'b0;
  logic       emerg_req = 1'b0, emerg_dir = 1'b0;
  logic [2:0] light_ns, light_ew, phase;
  logic       walk_ns, walk_ew;

  int n_vec = 0;
  int n_bad = 0;

  // model state: phase, ticks seen in phase, held emergency axis, ped latches, walk lamps
  int m_ph, m_cnt;
  bit m_hold, m_lns, m_lew, m_wns, m_wew;

  int lamp_ns_tab [0:5] = '{4, 1, 2, 4, 4, 4};
  int lamp_ew_tab [0:5] = '{4, 4, 4, 4, 1, 2};

  traffic_phase_sequencer #(.GREEN_TICKS(G), .YELLOW_TICKS(Y), .ALLRED_TICKS(A)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick_en    (tick_en),
    .ped_req_ns (ped_req_ns),
    .ped_req_ew (ped_req_ew),
    .emerg_req  (emerg_req),
    .emerg_dir  (emerg_dir),
    .light_ns   (light_ns),
    .light_ew   (light_ew),
    .walk_ns    (walk_ns),
    .walk_ew    (walk_ew),
    .phase      (phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int dur(input int p);
    case (p)
      1, 4:    return G;
      2, 5:    return Y;
      default: return A;
    endcase
  endfunction

  task automatic model_reset();
    m_ph = 0; m_cnt = 0; m_hold = 0;
    m_lns = 0; m_lew = 0; m_wns = 0; m_wew = 0;
  endtask

  task automatic model_step();
    int  nxt;
    bit  done;
    nxt  = m_ph;
    done = tick_en && (m_cnt + 1 == dur(m_ph));
    if (m_ph == 6) begin
      if (!emerg_req) nxt = m_hold ? 5 : 2;
    end else if ((m_ph == 1 || m_ph == 4) && emerg_req) begin
      if ((m_ph == 4) == emerg_dir) begin nxt = 6; m_hold = emerg_dir; end
      else nxt = m_ph + 1;
    end else if (done) begin
      if ((m_ph == 0 || m_ph == 3) && emerg_req) begin nxt = 6; m_hold = emerg_dir; end
      else nxt = (m_ph + 1) % 6;
    end
    if (nxt != m_ph) m_cnt = 0;
    else if (tick_en) m_cnt++;
    if (nxt == 1 && m_ph != 1) begin m_wns = m_lns; m_lns = ped_req_ns; end
    else m_lns = m_lns | ped_req_ns;
    if (nxt == 4 && m_ph != 4) begin m_wew = m_lew; m_lew = ped_req_ew; end
    else m_lew = m_lew | ped_req_ew;
    if (nxt != 1) m_wns = 0;
    if (nxt != 4) m_wew = 0;
    m_ph = nxt;
  endtask

  task automatic check_all();
    int ens, eew;
    if (m_ph == 6) begin
      ens = m_hold ? 4 : 1;
      eew = m_hold ? 1 : 4;
    end else begin
      ens = lamp_ns_tab[m_ph];
      eew = lamp_ew_tab[m_ph];
    end
    chk("phase",    8'(phase),    8'(m_ph));
    chk("light_ns", 8'(light_ns), 8'(ens));
    chk("light_ew", 8'(light_ew), 8'(eew));
    chk("walk_ns",  8'(walk_ns),  8'(m_wns));
    chk("walk_ew",  8'(walk_ew),  8'(m_wew));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1 check_all();
    @(negedge clk);
  endtask

  // asynchronous reset asserted away from any clock edge
  task automatic do_reset();
    #2 reset = 1'b1;
    #1 model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    check_all();
    @(negedge clk);
    reset = 1'b0;

    // fixed cadence, no requests: plain sequence with nominal durations
    for (int i = 0; i < 200; i++) begin
      tick_en = (i % 4 == 3);
      cyc();
    end

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 149) == 0) emerg_req = ~emerg_req;
      if ($urandom_range(0, 29) == 0)  emerg_dir = ~emerg_dir;
      tick_en    = (i >= 2500) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 3) == 0);
      ped_req_ns = ($urandom_range(0, 19) == 0);
      ped_req_ew = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 599) == 0) do_reset();
      else cyc();
    end

    tick_en = 1'b0; ped_req_ns = 1'b0; ped_req_ew = 1'b0;
    cyc();
    do_reset();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
